// File: rtl/alu_pkg.sv
// Shared ALU definitions for the sequential divider: state encoding and timing constants.
package alu_pkg;

    localparam int DIV_DATA_WIDTH = 32;
    localparam int DIV_LATENCY    = DIV_DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract divisor, keep or restore.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH:0]   rem_nxt,
    output logic [DATA_WIDTH-1:0] quo_nxt
);

    // One guard bit above the shifted remainder carries the trial sign.
    logic [DATA_WIDTH+1:0] rem_sh_s;
    logic [DATA_WIDTH+1:0] trial_s;

    // Trial subtraction and quotient-bit selection
    always_comb begin
        rem_sh_s = {rem, quo[DATA_WIDTH-1]};
        trial_s  = rem_sh_s - {2'b00, divisor};
        if (trial_s[DATA_WIDTH+1] == 1'b0) begin
            rem_nxt = trial_s[DATA_WIDTH:0];
            quo_nxt = {quo[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh_s[DATA_WIDTH:0];
            quo_nxt = {quo[DATA_WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider (DIV/DIVU): quotient on LO, remainder on HI.
// Optional macro DIV_ZERO_DETECT_EN adds a fast divide-by-zero path and the div_zero flag.
module div_seq
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] Q,
    input  logic [DATA_WIDTH-1:0] M,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic                  div_zero
`endif
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    div_state_e            state_r;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [DATA_WIDTH:0]   rem_r;
    logic [DATA_WIDTH-1:0] quo_r;
    logic [DATA_WIDTH-1:0] div_r;
    logic                  neg_q_r;
    logic                  neg_r_r;
    logic                  busy_r;
    logic                  done_r;
    logic [DATA_WIDTH-1:0] hi_r;
    logic [DATA_WIDTH-1:0] lo_r;
`ifdef DIV_ZERO_DETECT_EN
    logic                  div_zero_r;
    logic                  dz_r;
    logic [DATA_WIDTH-1:0] q_raw_r;
`endif

    logic [DATA_WIDTH-1:0] q_mag_s;
    logic [DATA_WIDTH-1:0] m_mag_s;
    logic [DATA_WIDTH:0]   rem_nxt_s;
    logic [DATA_WIDTH-1:0] quo_nxt_s;
    logic [DATA_WIDTH-1:0] lo_fix_s;
    logic [DATA_WIDTH-1:0] hi_fix_s;

    div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem     (rem_r),
        .quo     (quo_r),
        .divisor (div_r),
        .rem_nxt (rem_nxt_s),
        .quo_nxt (quo_nxt_s)
    );

    // Operand magnitudes and sign-corrected results
    always_comb begin
        q_mag_s  = (is_signed && Q[DATA_WIDTH-1]) ? (-Q) : Q;
        m_mag_s  = (is_signed && M[DATA_WIDTH-1]) ? (-M) : M;
        lo_fix_s = neg_q_r ? (-quo_r) : quo_r;
        hi_fix_s = neg_r_r ? (-rem_r[DATA_WIDTH-1:0]) : rem_r[DATA_WIDTH-1:0];
    end

    // Divider FSM with registered handshake and result outputs
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_r    <= DIV_IDLE;
            cnt_r      <= {CNT_WIDTH{1'b0}};
            rem_r      <= {(DATA_WIDTH+1){1'b0}};
            quo_r      <= {DATA_WIDTH{1'b0}};
            div_r      <= {DATA_WIDTH{1'b0}};
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            hi_r       <= {DATA_WIDTH{1'b0}};
            lo_r       <= {DATA_WIDTH{1'b0}};
`ifdef DIV_ZERO_DETECT_EN
            div_zero_r <= 1'b0;
            dz_r       <= 1'b0;
            q_raw_r    <= {DATA_WIDTH{1'b0}};
`endif
        end else begin
            busy_r <= (state_r == DIV_CALC) || (state_r == DIV_FIX);
            done_r <= (state_r == DIV_DONE);
            case (state_r)
                DIV_IDLE: begin
                    // done_r still high means this is the done cycle: start is dropped.
                    if (start && !done_r) begin
                        rem_r   <= {(DATA_WIDTH+1){1'b0}};
                        quo_r   <= q_mag_s;
                        div_r   <= m_mag_s;
                        neg_q_r <= is_signed & (Q[DATA_WIDTH-1] ^ M[DATA_WIDTH-1]);
                        neg_r_r <= is_signed & Q[DATA_WIDTH-1];
                        cnt_r   <= {CNT_WIDTH{1'b0}};
`ifdef DIV_ZERO_DETECT_EN
                        div_zero_r <= 1'b0;
                        q_raw_r    <= Q;
                        if (M == {DATA_WIDTH{1'b0}}) begin
                            dz_r    <= 1'b1;
                            state_r <= DIV_DONE;
                        end else begin
                            dz_r    <= 1'b0;
                            state_r <= DIV_CALC;
                        end
`else
                        state_r <= DIV_CALC;
`endif
                    end else begin
                        state_r <= DIV_IDLE;
                    end
                end
                DIV_CALC: begin
                    rem_r <= rem_nxt_s;
                    quo_r <= quo_nxt_s;
                    cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_CNT) begin
                        state_r <= DIV_FIX;
                    end else begin
                        state_r <= DIV_CALC;
                    end
                end
                DIV_FIX: begin
                    lo_r    <= lo_fix_s;
                    hi_r    <= hi_fix_s;
                    state_r <= DIV_DONE;
                end
                DIV_DONE: begin
`ifdef DIV_ZERO_DETECT_EN
                    if (dz_r) begin
                        hi_r       <= q_raw_r;
                        lo_r       <= {DATA_WIDTH{1'b1}};
                        div_zero_r <= 1'b1;
                    end else begin
                        div_zero_r <= 1'b0;
                    end
`endif
                    state_r <= DIV_IDLE;
                end
                default: begin
                    state_r <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign HI   = hi_r;
    assign LO   = lo_r;
`ifdef DIV_ZERO_DETECT_EN
    assign div_zero = div_zero_r;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq; honours DIV_ZERO_DETECT_EN when defined.
module tb_div_seq;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic        is_signed;
    logic [31:0] Q;
    logic [31:0] M;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
`ifdef DIV_ZERO_DETECT_EN
    logic        div_zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    div_seq #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .is_signed (is_signed),
        .Q         (Q),
        .M         (M),
        .busy      (busy),
        .done      (done),
        .HI        (HI),
        .LO        (LO)
`ifdef DIV_ZERO_DETECT_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op; lat = edges from accepting edge to first done, bcnt = edges with busy high.
    task automatic run_op(input logic sgn, input logic [31:0] q, input logic [31:0] m,
                          output int lat, output int bcnt, output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clock);
        Q = q; M = m; is_signed = sgn; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; Q = $urandom; M = $urandom; is_signed = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (busy) bcnt++;
        end
        hi = HI; lo = LO;
    endtask

    task automatic do_op(input string tag, input logic sgn, input logic [31:0] q, input logic [31:0] m,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int exp_lat);
        int lat, bcnt;
        logic [31:0] hi, lo;
        run_op(sgn, q, m, lat, bcnt, hi, lo);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(bcnt), 32'(exp_lat - 1));
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
        @(posedge clock); #1;
    endtask

    initial begin
        int e, first, second, ndone, dz_lat;
        longint qs, ms, eq, er;
        logic sgn;
        logic [31:0] rq, rm;

        clear_n = 1'b0; start = 1'b0; is_signed = 1'b0; Q = 32'd0; M = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
`ifdef DIV_ZERO_DETECT_EN
        check("rst_dz", {31'd0, div_zero}, 32'd0);
`endif
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock); #1;

        do_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34);
        do_op("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        do_op("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34);
        do_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34);
        do_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);

`ifdef DIV_ZERO_DETECT_EN
        dz_lat = 1;
`else
        dz_lat = 34;
`endif
        do_op("dz", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, dz_lat);
`ifdef DIV_ZERO_DETECT_EN
        check("dz_flag", {31'd0, div_zero}, 32'd1);
        do_op("dz_clr", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34);
        check("dz_flag_clr", {31'd0, div_zero}, 32'd0);
`endif

        // start pulsed mid-operation must not queue a second op
        @(negedge clock);
        Q = 32'd1000; M = 32'd10; is_signed = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        e = 0; ndone = 0; first = -1;
        repeat (80) begin
            @(posedge clock); #1;
            e++;
            start = (e == 9);
            if (done) begin
                ndone++;
                if (first < 0) first = e;
            end
        end
        start = 1'b0;
        check("mid_ndone", 32'(ndone), 32'd1);
        check("mid_lat", 32'(first), 32'd34);
        check("mid_lo", LO, 32'd100);
        check("mid_hi", HI, 32'd0);

        // start held high: the done cycle drops it, the next cycle accepts it
        @(negedge clock);
        Q = 32'd50; M = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        e = 0; first = -1; second = -1;
        while (second < 0 && e < 120) begin
            @(posedge clock); #1;
            e++;
            if (done) begin
                if (first < 0) first = e;
                else begin
                    second = e;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("held_first", 32'(first), 32'd34);
        check("held_gap", 32'(second - first), 32'd36);
        check("held_lo", LO, 32'd16);
        check("held_hi", HI, 32'd2);
        @(posedge clock); #1;

        // asynchronous reset at edge 20 aborts the operation
        @(negedge clock);
        Q = 32'd77; M = 32'd5; is_signed = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (20) @(posedge clock);
        clear_n = 1'b0;
        #1;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_done", {31'd0, done}, 32'd0);
        check("rstmid_hi", HI, 32'd0);
        check("rstmid_lo", LO, 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        ndone = 0;
        repeat (50) begin
            @(posedge clock); #1;
            if (done) ndone++;
        end
        check("rstmid_nodone", 32'(ndone), 32'd0);
        do_op("post_rst", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 34);

        // random regression against a 64-bit reference divide
        for (int i = 0; i < 150; i++) begin
            sgn = 1'($urandom_range(0, 1));
            rq  = $urandom;
            rm  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if ($urandom_range(0, 3) == 0) rm = -rm;
            if (rm == 32'd0) rm = 32'd1;
            if (sgn) begin
                qs = longint'($signed(rq));
                ms = longint'($signed(rm));
            end else begin
                qs = longint'({32'd0, rq});
                ms = longint'({32'd0, rm});
            end
            eq = qs / ms;
            er = qs % ms;
            do_op($sformatf("rnd%0d", i), sgn, rq, rm, 32'(eq), 32'(er), 34);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
